// File: rtl/uart_fmt_pkg.sv
// Shared constants and FSM encoding for the UART decimal formatter.
package uart_fmt_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_R     = 8'h52;

  // Longest string is '-' + 10 digits + CR LF = 13 characters.
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONV     = 3'd1,
    ST_ERR_SEND = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_formatter_if.sv
// Request/response and transmitter handshake bundle for uart_tx_formatter.
interface uart_tx_formatter_if #(
  parameter int DATA_BITS  = 8,
  parameter int VALUE_BITS = 32
);
  logic                  i_start;
  logic [VALUE_BITS-1:0] i_value;
  logic                  i_err;
  logic                  i_tx_done;
  logic                  o_tx_start;
  logic [DATA_BITS-1:0]  o_tx_data;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start, i_value, i_err, i_tx_done,
    input  o_tx_start, o_tx_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_value, i_err, i_tx_done,
    output o_tx_start, o_tx_data, o_busy, o_done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: the load cycle performs the first shift,
// so the BCD result and o_done appear exactly VALUE_BITS cycles after i_start.
module bin2bcd_seq #(
  parameter int VALUE_BITS = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [VALUE_BITS-1:0]   i_bin,
  output logic [4*MAX_DIGITS-1:0] o_bcd,
  output logic                    o_done
);
  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(VALUE_BITS + 1);

  logic [VALUE_BITS-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  unused_adj_msb;

  // Top digit never reaches 8 after correction, so its MSB is always dropped.
  assign unused_adj_msb = adj[BCD_W-1];

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (i_start) begin
      bcd_d = {{(BCD_W-1){1'b0}}, i_bin[VALUE_BITS-1]};
      bin_d = {i_bin[VALUE_BITS-2:0], 1'b0};
      cnt_d = CNT_W'(VALUE_BITS - 1);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj[BCD_W-2:0], bin_q[VALUE_BITS-1]};
      bin_d  = {bin_q[VALUE_BITS-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_bcd  = bcd_q;
  assign o_done = done_q;
endmodule

// File: rtl/uart_tx_formatter.sv
// Formats a signed result (or "ERR") as decimal ASCII + CR LF, one UART frame at a time.
//   state    | meaning
//   IDLE     | waiting for i_start
//   CONV     | binary-to-BCD conversion running
//   ERR_SEND | first 'E' of the error string being launched
//   SEND     | o_tx_start pulse for the current character
//   WAIT     | holding o_tx_data until the transmitter's done pulse
//   DONE     | o_done pulse, then back to IDLE
module uart_tx_formatter #(
  parameter int DATA_BITS  = 8,
  parameter int VALUE_BITS = 32,
  parameter int MAX_DIGITS = 10
) (
  input logic                i_clk,
  input logic                i_rst,
  uart_tx_formatter_if.slave bus
);
  import uart_fmt_pkg::*;

  localparam int BCD_W = 4 * MAX_DIGITS;

  state_t                state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  neg_q, neg_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      nxt_idx, first_dig, last_idx;
  logic [VALUE_BITS-1:0] mag;
  logic [BCD_W-1:0]      bcd;
  logic                  conv_go, conv_done;

  // Character at string position idx, with digits starting at the leading nonzero one.
  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx, input logic neg,
                                         input logic err, input logic [IDX_W-1:0] fd,
                                         input logic [BCD_W-1:0] digits);
    logic [IDX_W-1:0] pos, ndig, dsel;
    logic [3:0]       nib;
    pos  = idx - IDX_W'(neg);
    ndig = fd + 1'b1;
    dsel = fd - pos;
    nib  = 4'(digits >> (4 * int'(dsel)));
    char_at = ASCII_LF;
    if (err) begin
      case (idx)
        IDX_W'(0):            char_at = ASCII_E;
        IDX_W'(1), IDX_W'(2): char_at = ASCII_R;
        IDX_W'(3):            char_at = ASCII_CR;
        default:              char_at = ASCII_LF;
      endcase
    end else if (neg && idx == '0) begin
      char_at = ASCII_MINUS;
    end else if (pos < ndig) begin
      char_at = ASCII_ZERO + {4'b0000, nib};
    end else if (pos == ndig) begin
      char_at = ASCII_CR;
    end
  endfunction

  always_comb begin
    mag = bus.i_value[VALUE_BITS-1] ? (~bus.i_value + 1'b1) : bus.i_value;
  end

  bin2bcd_seq #(
    .VALUE_BITS (VALUE_BITS),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (conv_go),
    .i_bin   (mag),
    .o_bcd   (bcd),
    .o_done  (conv_done)
  );

  // Highest nonzero digit wins; all-zero leaves digit 0 so zero prints "0".
  always_comb begin
    first_dig = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) first_dig = IDX_W'(i);
    end
  end

  always_comb begin
    if (err_q) last_idx = IDX_W'(4);
    else       last_idx = first_dig + IDX_W'(2) + IDX_W'(neg_q);
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    neg_d      = neg_q;
    err_d      = err_q;
    conv_go    = 1'b0;
    nxt_idx    = idx_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          busy_d = 1'b1;
          idx_d  = '0;
          err_d  = bus.i_err;
          neg_d  = bus.i_value[VALUE_BITS-1] & ~bus.i_err;
          if (bus.i_err) begin
            state_d    = ST_ERR_SEND;
            tx_start_d = 1'b1;
            tx_data_d  = DATA_BITS'(ASCII_E);
          end else begin
            state_d = ST_CONV;
            conv_go = 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d    = ST_SEND;
          tx_start_d = 1'b1;
          tx_data_d  = DATA_BITS'(char_at(idx_q, neg_q, err_q, first_dig, bcd));
        end
      end
      ST_ERR_SEND, ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (idx_q == last_idx) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = ST_SEND;
            idx_d      = nxt_idx;
            tx_start_d = 1'b1;
            tx_data_d  = DATA_BITS'(char_at(nxt_idx, neg_q, err_q, first_dig, bcd));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
endmodule
